// File: rtl/idecode_useq.sv
// Instruction decode micro-sequencer: accepts one fetch bundle and expands it
// into instr[25:24]+1 micro-ops, handing them to execute with registered outputs.
module idecode_useq (
    input  logic        clk,
    input  logic        rst,
    input  logic [49:0] fetch_idecode_interface,
    input  logic        flush_pipeline,
    input  logic        exec_ready,
    output logic        dec_ready,
    output logic [52:0] idecode_exec_interface
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [1:0]  upc_q, upc_d;
    logic        last_q, last_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        pred_q, pred_d;
    logic [31:0] instr_q, instr_d;

    logic        fe_valid;
    logic [7:0]  fe_tgt;
    logic [7:0]  fe_pc;
    logic        fe_pred;
    logic [31:0] fe_instr;
    logic        at_end;
    logic        accept;

    assign fe_valid = fetch_idecode_interface[0];
    assign fe_tgt   = fetch_idecode_interface[8:1];
    assign fe_pc    = fetch_idecode_interface[16:9];
    assign fe_pred  = fetch_idecode_interface[17];
    assign fe_instr = fetch_idecode_interface[49:18];

    // instr[25:24] is N-1, i.e. the index of the final micro-op
    assign at_end    = (upc_q == instr_q[25:24]);
    assign dec_ready = (state_q == IDLE) || at_end;
    assign accept    = fe_valid && dec_ready && exec_ready && !flush_pipeline;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        upc_d   = upc_q;
        last_d  = last_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pred_d  = pred_q;
        instr_d = instr_q;
        if (flush_pipeline) begin
            state_d = IDLE;
            valid_d = 1'b0;
            upc_d   = 2'd0;
            last_d  = 1'b0;
        end else if (exec_ready) begin
            if (accept) begin
                if (fe_instr != 32'd0) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    upc_d   = 2'd0;
                    last_d  = (fe_instr[25:24] == 2'd0);
                    pc_d    = fe_pc;
                    tgt_d   = fe_tgt;
                    pred_d  = fe_pred;
                    instr_d = fe_instr;
                end else begin
                    // all-zero instruction is a fetch bubble: nothing latched
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end else if (state_q == ISSUE) begin
                if (!at_end) begin
                    upc_d  = upc_q + 2'd1;
                    last_d = ((upc_q + 2'd1) == instr_q[25:24]);
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            upc_q   <= 2'd0;
            last_q  <= 1'b0;
            pc_q    <= 8'd0;
            tgt_q   <= 8'd0;
            pred_q  <= 1'b0;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            upc_q   <= upc_d;
            last_q  <= last_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pred_q  <= pred_d;
            instr_q <= instr_d;
        end
    end

    assign idecode_exec_interface = {instr_q, tgt_q, pred_q, pc_q, last_q, upc_q, valid_q};

endmodule
